// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: FSM state encoding, default
// select width, settle-counter width and the select-bit to mux-pin mapping.
package mux_scan_pkg;

  // Default select width; the channel count is 2**SEL_W.
  localparam int unsigned SEL_W_DEF = 4;

  // Settle counter width; wide enough for the legal SETTLE range 1..15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Mux select pin driven by logical select bit bit_idx (bit0 = lowest-order pin).
  function automatic int unsigned sel_pin_idx(input int unsigned bit_idx);
    return bit_idx;
  endfunction

endpackage

// File: rtl/mux_scan_seq_if.sv
// Downstream word handshake of the mux scan sequencer.
//   word_pad  : captured word, bit i = sample of channel i
//   valid_pad : word_pad valid, held until accepted
//   ready_pad : downstream accept
interface mux_scan_seq_if #(
  parameter int unsigned SEL_W = 4
);
  localparam int unsigned WORD_W = 2**SEL_W;

  logic [WORD_W-1:0] word_pad;
  logic              valid_pad;
  logic              ready_pad;

  modport master (output word_pad, output valid_pad, input ready_pad);
  modport slave  (input word_pad, input valid_pad, output ready_pad);
endinterface

// File: rtl/mux_scan_settle_cnt.sv
// Loadable down-counter with zero flag; times the SETTLE wait after a select change.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (wins over dec)
//   load_val   : value to load
//   dec        : decrement, saturating at zero
//   zero_c     : counter currently zero (decode of the count register)
module mux_scan_settle_cnt
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_seq.sv
// Sequencer around a 16:1 mux stage: steps the select through every channel,
// waits SETTLE cycles per channel, samples the mux output into a word and
// offers the word downstream on a valid/ready handshake.
//   clk_pad, rst_n_pad : clock, async active-low reset
//   start_pad          : begin a scan (accepted only in IDLE)
//   abort_pad          : synchronous return to IDLE, highest priority
//   mux_out_pad        : mux stage output
//   sel_pad, en_pad    : mux select / enable
//   busy_pad           : scan in progress (state != IDLE)
//   dn                 : word_pad / valid_pad / ready_pad handshake
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int unsigned SEL_W  = SEL_W_DEF,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk_pad,
  input  logic             rst_n_pad,
  input  logic             start_pad,
  input  logic             abort_pad,
  input  logic             mux_out_pad,
  output logic [SEL_W-1:0] sel_pad,
  output logic             en_pad,
  output logic             busy_pad,
  mux_scan_seq_if.master   dn
);

  localparam int unsigned    N_CH     = 2**SEL_W;
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_t            state_q, state_nxt;
  logic [SEL_W-1:0]  sel_q, sel_nxt;
  logic              en_q, en_nxt;
  logic              valid_q, valid_nxt;
  logic              busy_q, busy_nxt;
  logic [N_CH-1:0]   word_q, word_nxt;
  logic              cnt_load, cnt_dec, cnt_zero_c;

  mux_scan_settle_cnt u_settle_cnt (
    .clk      (clk_pad),
    .rst_n    (rst_n_pad),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero_c)
  );

  // State and output registers
  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_nxt;
      sel_q   <= sel_nxt;
      en_q    <= en_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
      word_q  <= word_nxt;
    end
  end

  // Next-state and next-output logic; abort overrides every other event
  always_comb begin
    state_nxt = state_q;
    sel_nxt   = sel_q;
    en_nxt    = en_q;
    valid_nxt = valid_q;
    word_nxt  = word_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;

    if (abort_pad) begin
      // Partial word is kept on purpose; the next start clears it.
      state_nxt = ST_IDLE;
      sel_nxt   = '0;
      en_nxt    = 1'b0;
      valid_nxt = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_pad) begin
            state_nxt = ST_SETTLE;
            sel_nxt   = '0;
            en_nxt    = 1'b1;
            word_nxt  = '0;
            cnt_load  = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero_c) begin
            state_nxt = ST_SAMPLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_SAMPLE: begin
          word_nxt[sel_q] = mux_out_pad;
          if (sel_q != SEL_MAX) begin
            state_nxt = ST_SETTLE;
            sel_nxt   = sel_q + SEL_W'(1);
            cnt_load  = 1'b1;
          end else begin
            // Last channel: park select at max rather than wrapping.
            state_nxt = ST_HOLD;
            en_nxt    = 1'b0;
            valid_nxt = 1'b1;
          end
        end
        ST_HOLD: begin
          if (valid_q && dn.ready_pad) begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
            sel_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // Route logical select bits onto the mux select pins
  for (genvar i = 0; i < int'(SEL_W); i++) begin : g_sel_map
    assign sel_pad[sel_pin_idx(i)] = sel_q[i];
  end

  assign en_pad       = en_q;
  assign busy_pad     = busy_q;
  assign dn.word_pad  = word_q;
  assign dn.valid_pad = valid_q;

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Sequencer that drives the select and enable inputs of the 16:1 combinational mux stage.
- Steps the select through all 16 data channels and samples the 1-bit mux output for each one.
- Assembles the samples into a 16-bit word and hands it downstream on a valid/ready handshake.
- Sits directly around the mux stage: its outputs feed the mux select/enable pins and its capture input consumes the mux output.

Parameters:
- SEL_W, 4, select width; channel count is 2**SEL_W (16).
- SETTLE, 2, settle cycles after each select change before sampling; legal range 1..15.

Ports:
- clk_pad  in  1  single clock, rising edge.
- rst_n_pad  in  1  asynchronous active-low reset.
- start_pad  in  1  one-cycle request to begin a scan; ignored unless IDLE.
- abort_pad  in  1  synchronous abort; returns to IDLE from any state.
- mux_out_pad  in  1  output of the mux stage.
- sel_pad  out  SEL_W  channel select driven to the mux stage.
- en_pad  out  1  mux enable; when low the mux output is 0.
- busy_pad  out  1  high in SETTLE, SAMPLE and HOLD.
- word_pad  out  2**SEL_W  captured word; bit i holds the sample of channel i.
- valid_pad  out  1  word_pad is valid; held until accepted.
- ready_pad  in  1  downstream accept.

Behaviour:
- Reset (asynchronous, rst_n_pad=0): state=IDLE, sel_pad=0, en_pad=0, busy_pad=0, word_pad=0, valid_pad=0, settle counter=0.
- All outputs are registered. No combinational path exists from any input to any output.
- IDLE:
  - start_pad=1 -> SETTLE with sel=0, en=1, cnt=SETTLE-1, word cleared to 0.
- SETTLE:
  - cnt!=0 -> decrement cnt.
  - cnt==0 -> SAMPLE.
  - sel and en are held stable throughout.
- SAMPLE (one cycle):
  - word[sel] <= mux_out_pad.
  - sel != 2**SEL_W-1 -> sel+1, cnt=SETTLE-1, go to SETTLE.
  - sel at max -> go to HOLD with en=0, valid=1. sel stays at max (no wrap).
- HOLD:
  - word_pad is frozen.
  - valid_pad && ready_pad in the same cycle -> IDLE, valid=0, sel=0.
  - ready_pad while valid is low has no effect.
- Timing per channel: SETTLE+1 cycles.
- Latency: valid_pad rises 16*(SETTLE+1) clock edges after the edge that accepts start_pad (48 for SETTLE=2).
- start_pad while busy is ignored and does not restart the scan.
- start_pad in the same cycle as a HOLD handshake is ignored; the next start is accepted from IDLE.
- abort_pad has priority over every other event, including a same-cycle start or handshake.
  - Effect: IDLE, en=0, valid=0, sel=0.
  - word_pad keeps its partial contents until the next start.
- Asynchronous reset mid-scan forces the reset values immediately; no partial word is ever presented.
- Width rule: sel increments modulo 2**SEL_W, but the SAMPLE-at-max transition prevents any wrap.
- busy_pad = (state != IDLE).

Decomposition:
- Shared package mux_scan_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, HOLD}, 2 bits;
  - SEL_W default;
  - the mapping of sel_pad bits onto the mux select pins (bit0 = lowest-order select).
- One natural sub-module, mux_scan_settle_cnt: a loadable down-counter with a zero flag, used for the SETTLE wait.

Test Plan:
1. Reset mid-scan: assert rst_n_pad=0 at cycle 20 after start -> all outputs read 0 in the same cycle. With SETTLE=2 and every mux channel forced to 1, no valid appears for the next 60 cycles.
2. Full scan: mux model returns channel pattern 16'hA5C3 -> valid_pad rises exactly 48 edges after start; word_pad=16'hA5C3; en_pad=0 in HOLD.
3. Backpressure: hold ready_pad=0 for 10 cycles after valid -> word and valid are stable throughout; ready=1 -> IDLE next edge, busy=0.
4. Abort at channel 7: pattern 16'hFFFF -> IDLE, valid never rises, word_pad=16'h007F retained; a new start then clears the word to 0.
5. Start while busy: pulse start_pad at channels 3 and 15 -> scan timing unchanged, valid still at edge 48.
6. SETTLE=1 build: pattern 16'h1234 -> valid at edge 32. The sel_pad trace must show each value 0..15 held exactly 2 cycles.
